// File: rtl/i2c_packet_fifo_if.sv
// Frame-in / word-out bus between the frame counter stage, the packet FIFO and the host logic.
// The FIFO connects through the slave modport; host-side logic uses master.
interface i2c_packet_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [8:0]      DATA_REG;
    logic            VALID_PACK;
    logic            RD_EN;
    logic            CLR_OVF;
    logic [8:0]      RD_DATA;
    logic            RD_VALID;
    logic            EMPTY;
    logic            FULL;
    logic [ADDR_W:0] COUNT;
    logic            OVERFLOW;

    modport slave (
        input  DATA_REG, VALID_PACK, RD_EN, CLR_OVF,
        output RD_DATA, RD_VALID, EMPTY, FULL, COUNT, OVERFLOW
    );

    modport master (
        output DATA_REG, VALID_PACK, RD_EN, CLR_OVF,
        input  RD_DATA, RD_VALID, EMPTY, FULL, COUNT, OVERFLOW
    );
endinterface

// File: rtl/i2c_packet_fifo.sv
// Circular FIFO of 9-bit frame words: captures DATA_REG on each VALID_PACK rising edge,
// serves words through a registered read handshake, flags dropped frames sticky.
module i2c_packet_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic                 SYNCED_CLK,
    input logic                 RST,
    i2c_packet_fifo_if.slave    bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [8:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_vp_d;
    logic [8:0]        r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;

    logic w_empty, w_full, w_we, w_re, w_wr, w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_we    = bus.VALID_PACK & ~r_vp_d;
    assign w_re    = bus.RD_EN & ~w_empty;
    // A full FIFO still takes the frame when a read frees a slot on the same edge.
    assign w_wr    = w_we & (~w_full | w_re);
    assign w_drop  = w_we & w_full & ~w_re;

    always_ff @(posedge SYNCED_CLK) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.DATA_REG;
    end

    always_ff @(posedge SYNCED_CLK) begin
        if (RST) begin
            // Delay reg starts high so a level already present at release is not a new frame.
            r_vp_d     <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_vp_d     <= bus.VALID_PACK;
            r_rd_valid <= w_re;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_re) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_re})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)           r_overflow <= 1'b1;
            else if (bus.CLR_OVF) r_overflow <= 1'b0;
        end
    end

    assign bus.RD_DATA  = r_rd_data;
    assign bus.RD_VALID = r_rd_valid;
    assign bus.EMPTY    = w_empty;
    assign bus.FULL     = w_full;
    assign bus.COUNT    = r_count;
    assign bus.OVERFLOW = r_overflow;
endmodule

// File: tb/tb_i2c_packet_fifo.sv
// Directed bench for i2c_packet_fifo with a queue scoreboard of expected read words.
module tb_i2c_packet_fifo;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] sb[$];

    i2c_packet_fifo_if #(.ADDR_W(4)) bus ();

    i2c_packet_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .SYNCED_CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Clean 0->1->0 frame pulse; the model accepts it only if there is room.
    task automatic send_frame(input logic [8:0] d);
        bus.DATA_REG   = d;
        bus.VALID_PACK = 1'b1;
        tick();
        bus.VALID_PACK = 1'b0;
        if (sb.size() < 16) sb.push_back(d);
        tick();
    endtask

    task automatic read_one(input string tag);
        logic [8:0] exp;
        bus.RD_EN = 1'b1;
        tick();
        bus.RD_EN = 1'b0;
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h000;
        chk({tag, "_vld"}, bus.RD_VALID, 1);
        chk({tag, "_dat"}, bus.RD_DATA, exp);
    endtask

    initial begin
        bus.DATA_REG = '0; bus.VALID_PACK = 1'b1; bus.RD_EN = 1'b0; bus.CLR_OVF = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_count", bus.COUNT, 0);
        chk("rst_empty", bus.EMPTY, 1);
        chk("rst_full",  bus.FULL, 0);
        chk("rst_ovf",   bus.OVERFLOW, 0);
        chk("rst_rdv",   bus.RD_VALID, 0);
        chk("rst_rdd",   bus.RD_DATA, 0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("vp_held_release", bus.COUNT, 0);
        bus.VALID_PACK = 1'b0;
        tick();

        // Single frame with a long VALID_PACK level
        bus.DATA_REG = 9'h1A5; bus.VALID_PACK = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("single_count", bus.COUNT, 1);
        bus.VALID_PACK = 1'b0;
        sb.push_back(9'h1A5);
        tick();
        chk("single_count2", bus.COUNT, 1);
        read_one("single_rd");
        chk("single_empty", bus.EMPTY, 1);
        tick();
        chk("single_rdv_pulse", bus.RD_VALID, 0);
        chk("single_rdd_hold", bus.RD_DATA, 9'h1A5);

        // Fill and wrap
        for (int i = 0; i < 16; i++) send_frame(9'(i));
        chk("fill_full",  bus.FULL, 1);
        chk("fill_count", bus.COUNT, 16);
        for (int i = 0; i < 4; i++) read_one("wrap_rd4");
        for (int i = 0; i < 4; i++) send_frame(9'h100 + 9'(i));
        chk("wrap_count", bus.COUNT, 16);
        for (int i = 0; i < 16; i++) read_one("wrap_drain");
        chk("wrap_empty", bus.EMPTY, 1);

        // Overflow and sticky clear
        for (int i = 0; i < 16; i++) send_frame(9'h020 + 9'(i));
        send_frame(9'h0FF);
        chk("ovf_set",   bus.OVERFLOW, 1);
        chk("ovf_count", bus.COUNT, 16);
        bus.CLR_OVF = 1'b1; tick(); bus.CLR_OVF = 1'b0;
        chk("ovf_clr", bus.OVERFLOW, 0);
        bus.DATA_REG = 9'h0FE; bus.VALID_PACK = 1'b1; bus.CLR_OVF = 1'b1;
        tick();
        chk("ovf_drop_wins_clr", bus.OVERFLOW, 1);
        bus.VALID_PACK = 1'b0; bus.CLR_OVF = 1'b0;
        tick();
        bus.CLR_OVF = 1'b1; tick(); bus.CLR_OVF = 1'b0;
        chk("ovf_clr2", bus.OVERFLOW, 0);

        // Full + write + read: oldest word out, new word in
        bus.DATA_REG = 9'h1EE; bus.VALID_PACK = 1'b1; bus.RD_EN = 1'b1;
        tick();
        bus.VALID_PACK = 1'b0; bus.RD_EN = 1'b0;
        chk("fullrw_vld", bus.RD_VALID, 1);
        chk("fullrw_dat", bus.RD_DATA, sb.pop_front());
        sb.push_back(9'h1EE);
        chk("fullrw_count", bus.COUNT, 16);
        chk("fullrw_ovf", bus.OVERFLOW, 0);
        tick();
        for (int i = 0; i < 16; i++) read_one("fullrw_drain");
        chk("drain_empty", bus.EMPTY, 1);

        // Empty + write + read: no bypass
        bus.DATA_REG = 9'h155; bus.VALID_PACK = 1'b1; bus.RD_EN = 1'b1;
        tick();
        bus.VALID_PACK = 1'b0; bus.RD_EN = 1'b0;
        sb.push_back(9'h155);
        chk("emptyrw_vld", bus.RD_VALID, 0);
        chk("emptyrw_hold", bus.RD_DATA, 9'h1EE);
        chk("emptyrw_count", bus.COUNT, 1);
        read_one("emptyrw_next");

        // Reset mid-stream
        for (int i = 0; i < 5; i++) send_frame(9'h0A0 + 9'(i));
        chk("mid_count5", bus.COUNT, 5);
        rst = 1'b1; tick(); rst = 1'b0;
        sb.delete();
        chk("mid_count0", bus.COUNT, 0);
        chk("mid_empty", bus.EMPTY, 1);
        bus.RD_EN = 1'b1; tick(); bus.RD_EN = 1'b0;
        chk("mid_rd_empty", bus.RD_VALID, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_packet_fifo.md
Name: i2c_packet_fifo

Overview:
- Downstream consumer of the frame counter stage; buffers each validated 9-bit frame word for the host-side logic.
- Detects the rising edge of VALID_PACK, captures DATA_REG into a circular FIFO and serves words via a registered read handshake.
- Reports fill level and empty/full status, plus a sticky overflow flag when frames arrive faster than they are drained.

Parameters:
- DEPTH, 16, number of 9-bit entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- SYNCED_CLK  input  1  block clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- DATA_REG  input  9  frame payload from the counter stage; stable while VALID_PACK is high.
- VALID_PACK  input  1  frame-valid level from the counter stage; may stay high for many cycles.
- RD_EN  input  1  read request; one word per cycle while high and not EMPTY.
- CLR_OVF  input  1  clears OVERFLOW.
- RD_DATA  output  9  word read out; updates only on an accepted read.
- RD_VALID  output  1  one-cycle pulse: RD_DATA is updated this cycle.
- EMPTY  output  1  COUNT==0.
- FULL  output  1  COUNT==DEPTH.
- COUNT  output  ADDR_W+1  current number of stored words.
- OVERFLOW  output  1  sticky: a frame was dropped because the FIFO was full.

Behaviour:
- Reset (RST=1 at a rising edge): WR_PTR=0, RD_PTR=0, COUNT=0, RD_DATA=0, RD_VALID=0, OVERFLOW=0, EMPTY=1, FULL=0.
- Reset also sets the VALID_PACK delay register to 1, so a VALID_PACK already high at reset release is not captured.
- Reset mid-operation discards all stored words. Memory contents are don't-care after reset.
- Write event WE = VALID_PACK & ~VALID_PACK_D, where VALID_PACK_D is VALID_PACK registered once. There is exactly one WE per low-to-high transition.
- On WE, DATA_REG is sampled in the same cycle as the edge is detected.
- Write accepted when WE & (~FULL | RE_OK): mem[WR_PTR] <= DATA_REG, and WR_PTR increments, wrapping DEPTH-1 -> 0.
- Read accepted (RE_OK) when RD_EN & ~EMPTY: RD_DATA <= mem[RD_PTR] on that edge, RD_VALID=1 for that cycle only, RD_PTR increments and wraps. Latency is 1 cycle from RD_EN sampled to RD_DATA/RD_VALID.
- Read on empty is ignored: RD_VALID=0 and RD_DATA holds its last value. A write in the same cycle does not make that read succeed; no bypass.
- Simultaneous write and read when full: both are accepted and COUNT stays at DEPTH. The read returns the oldest word, never the incoming one.
- Simultaneous write and read when neither full nor empty: COUNT is unchanged.
- COUNT: +1 on write only, -1 on read only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Overflow: WE & FULL & ~RE_OK drops the frame (pointers and memory unchanged) and sets OVERFLOW=1 on that edge.
- OVERFLOW is cleared by CLR_OVF=1. If CLR_OVF and a new drop occur in the same cycle, OVERFLOW stays 1.
- EMPTY, FULL and COUNT are registered, or derived combinationally from the registered COUNT; they are valid the cycle after the update.
- FIFO order is strict; words are read out in write order.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, RD_VALID=0. Hold VALID_PACK=1 across reset release -> no write, COUNT stays 0.
- Single frame: DATA_REG=9'h1A5, VALID_PACK 0->1 held 8 cycles -> COUNT=1 exactly once. RD_EN one cycle -> next cycle RD_DATA=9'h1A5, RD_VALID=1 for 1 cycle, EMPTY=1.
- Fill and wrap: 16 frames 9'h000..9'h00F -> FULL=1, COUNT=16. Read 4, write 9'h100..9'h103, then read all 16 -> output 9'h004..9'h00F, 9'h100..9'h103 in order; pointers wrapped.
- Overflow: when FULL, send frame 9'h0FF with RD_EN=0 -> dropped, OVERFLOW=1, COUNT=16. Pulse CLR_OVF -> OVERFLOW=0. Next drop coinciding with CLR_OVF -> OVERFLOW=1.
- Simultaneous at boundaries:
  - Full plus WE plus RD_EN -> RD_DATA=oldest word, COUNT=16, OVERFLOW=0.
  - Empty plus WE plus RD_EN -> RD_VALID=0, COUNT=1. The word is then readable next cycle.
- Reset mid-stream: COUNT=5, assert RST one cycle -> COUNT=0, EMPTY=1. A subsequent RD_EN yields RD_VALID=0.
